// File: rtl/stream_checker_pkg.sv
// Shared constants and helpers for the stream checker.
package stream_checker_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 8;

    // Saturating increment; callers pass their own all-ones limit so any CNT_W up to 32 works.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        if (value >= max_value) begin
            sat_inc = max_value;
        end else begin
            sat_inc = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/stream_checker_ref_delay_line.sv
// Reference delay line: DEPTH stages of {valid, data}, shifting every clock.
module ref_delay_line #(
    parameter int W     = 3,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_r [DEPTH];

    // Shift register; a reset flushes every in-flight sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/stream_checker.sv
// Compares a fixed-latency DUT output against a delayed copy of its stimulus,
// counting samples and mismatches and capturing the first failing pair.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int DATA_W  = 2,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] stim,
    input  logic [DATA_W-1:0] dut_out,
    output logic              err_pulse,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  smp_cnt,
    output logic [DATA_W-1:0] first_exp,
    output logic [DATA_W-1:0] first_got
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("stream_checker: LATENCY must be within 1..8");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("stream_checker: CNT_W must be within 1..32");
    end

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [DATA_W:0]   tail_s;
    logic              tail_valid_s;
    logic [DATA_W-1:0] tail_data_s;
    logic              mismatch_s;
    logic [CNT_W-1:0]  smp_base_s, err_base_s, smp_next_s, err_next_s;
    logic              flag_base_s, flag_next_s;
    logic [DATA_W-1:0] exp_base_s, got_base_s, exp_next_s, got_next_s;

    ref_delay_line #(
        .W     (DATA_W + 1),
        .DEPTH (LATENCY)
    ) u_ref_delay_line (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  ({en, stim}),
        .dout (tail_s)
    );

    assign tail_valid_s = tail_s[DATA_W];
    assign tail_data_s  = tail_s[DATA_W-1:0];
    assign mismatch_s   = tail_valid_s && (dut_out != tail_data_s);

    // Next-state of counters and capture: clear is applied first, then the compare.
    always_comb begin
        smp_base_s  = clr ? '0 : smp_cnt;
        err_base_s  = clr ? '0 : err_cnt;
        flag_base_s = clr ? 1'b0 : err_flag;
        exp_base_s  = clr ? '0 : first_exp;
        got_base_s  = clr ? '0 : first_got;

        smp_next_s  = smp_base_s;
        err_next_s  = err_base_s;
        flag_next_s = flag_base_s;
        exp_next_s  = exp_base_s;
        got_next_s  = got_base_s;

        if (tail_valid_s) begin
            smp_next_s = CNT_W'(sat_inc(32'(smp_base_s), CNT_MAX));
        end else begin
            smp_next_s = smp_base_s;
        end

        if (mismatch_s) begin
            err_next_s = CNT_W'(sat_inc(32'(err_base_s), CNT_MAX));
            if (!flag_base_s) begin
                flag_next_s = 1'b1;
                exp_next_s  = tail_data_s;
                got_next_s  = dut_out;
            end else begin
                flag_next_s = flag_base_s;
            end
        end else begin
            err_next_s = err_base_s;
        end
    end

    // Output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            err_pulse <= 1'b0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            smp_cnt   <= '0;
            first_exp <= '0;
            first_got <= '0;
        end else begin
            err_pulse <= mismatch_s;
            err_flag  <= flag_next_s;
            err_cnt   <= err_next_s;
            smp_cnt   <= smp_next_s;
            first_exp <= exp_next_s;
            first_got <= got_next_s;
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
// Self-checking bench: three checker instances (different LATENCY/CNT_W) against a cycle-history reference model.
module tb_stream_checker;

    localparam int N = 3;
    localparam int LAT  [N] = '{1, 3, 2};
    localparam int CMAX [N] = '{65535, 65535, 15};
    localparam int HIST = 4096;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] stim = 2'd0;
    logic [1:0] d_out [N];

    logic        pulse0, pulse1, pulse2, flag0, flag1, flag2;
    logic [15:0] ecnt0, scnt0, ecnt1, scnt1;
    logic [3:0]  ecnt2, scnt2;
    logic [1:0]  fexp0, fgot0, fexp1, fgot1, fexp2, fgot2;

    int o_pulse [N], o_flag [N], o_err [N], o_smp [N], o_fexp [N], o_fgot [N];

    int m_pulse [N], m_flag [N], m_err [N], m_smp [N], m_fexp [N], m_fgot [N];
    bit         en_h   [HIST];
    logic [1:0] stim_h [HIST];
    bit         rst_h  [HIST];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int pcnt2 = 0;

    always #5 sys_clk = ~sys_clk;

    stream_checker #(.DATA_W(2), .LATENCY(1), .CNT_W(16)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .clr(clr), .stim(stim), .dut_out(d_out[0]),
        .err_pulse(pulse0), .err_flag(flag0), .err_cnt(ecnt0), .smp_cnt(scnt0),
        .first_exp(fexp0), .first_got(fgot0));
    stream_checker #(.DATA_W(2), .LATENCY(3), .CNT_W(16)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .clr(clr), .stim(stim), .dut_out(d_out[1]),
        .err_pulse(pulse1), .err_flag(flag1), .err_cnt(ecnt1), .smp_cnt(scnt1),
        .first_exp(fexp1), .first_got(fgot1));
    stream_checker #(.DATA_W(2), .LATENCY(2), .CNT_W(4)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .clr(clr), .stim(stim), .dut_out(d_out[2]),
        .err_pulse(pulse2), .err_flag(flag2), .err_cnt(ecnt2), .smp_cnt(scnt2),
        .first_exp(fexp2), .first_got(fgot2));

    assign o_pulse[0] = 32'(pulse0); assign o_flag[0] = 32'(flag0);
    assign o_err[0]   = 32'(ecnt0);  assign o_smp[0]  = 32'(scnt0);
    assign o_fexp[0]  = 32'(fexp0);  assign o_fgot[0] = 32'(fgot0);
    assign o_pulse[1] = 32'(pulse1); assign o_flag[1] = 32'(flag1);
    assign o_err[1]   = 32'(ecnt1);  assign o_smp[1]  = 32'(scnt1);
    assign o_fexp[1]  = 32'(fexp1);  assign o_fgot[1] = 32'(fgot1);
    assign o_pulse[2] = 32'(pulse2); assign o_flag[2] = 32'(flag2);
    assign o_err[2]   = 32'(ecnt2);  assign o_smp[2]  = 32'(scnt2);
    assign o_fexp[2]  = 32'(fexp2);  assign o_fgot[2] = 32'(fgot2);

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A sample enabled at edge t-L is compared at edge t unless a reset hit any edge in between.
    function automatic bit is_valid(input int i, input int t);
        int l;
        l = LAT[i];
        if (t < l) return 1'b0;
        if (!en_h[t-l]) return 1'b0;
        for (int k = t - l; k <= t; k++) begin
            if (rst_h[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // mode: 0 clean, 1 random corruption, 2 turn expected 2 into 0, 3 always corrupt.
    task automatic step(input logic e, input logic [1:0] s, input logic c, input logic r, input int mode);
        logic [1:0] v;
        logic [1:0] expv;
        en = e; stim = s; clr = c; sys_rst = r;
        en_h[cyc] = e; stim_h[cyc] = s; rst_h[cyc] = r;
        for (int i = 0; i < N; i++) begin
            if (is_valid(i, cyc)) begin
                v = stim_h[cyc - LAT[i]];
                case (mode)
                    1: if ($urandom_range(0, 3) == 0) v = v ^ 2'($urandom_range(1, 3));
                    2: if (v == 2'd2) v = 2'd0;
                    3: v = v ^ 2'b01;
                    default: v = v;
                endcase
                d_out[i] = v;
            end else begin
                d_out[i] = 2'($urandom_range(0, 3));
            end
        end
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                m_pulse[i] = 0; m_flag[i] = 0; m_err[i] = 0; m_smp[i] = 0; m_fexp[i] = 0; m_fgot[i] = 0;
            end else begin
                if (c) begin
                    m_flag[i] = 0; m_err[i] = 0; m_smp[i] = 0; m_fexp[i] = 0; m_fgot[i] = 0;
                end
                m_pulse[i] = 0;
                if (is_valid(i, cyc)) begin
                    expv = stim_h[cyc - LAT[i]];
                    m_smp[i] = (m_smp[i] >= CMAX[i]) ? CMAX[i] : m_smp[i] + 1;
                    if (d_out[i] != expv) begin
                        m_err[i] = (m_err[i] >= CMAX[i]) ? CMAX[i] : m_err[i] + 1;
                        m_pulse[i] = 1;
                        if (m_flag[i] == 0) begin
                            m_flag[i] = 1; m_fexp[i] = 32'(expv); m_fgot[i] = 32'(d_out[i]);
                        end
                    end
                end
            end
            check_eq($sformatf("pulse%0d", i), o_pulse[i], m_pulse[i]);
            check_eq($sformatf("flag%0d", i),  o_flag[i],  m_flag[i]);
            check_eq($sformatf("err_cnt%0d", i), o_err[i], m_err[i]);
            check_eq($sformatf("smp_cnt%0d", i), o_smp[i], m_smp[i]);
            check_eq($sformatf("first_exp%0d", i), o_fexp[i], m_fexp[i]);
            check_eq($sformatf("first_got%0d", i), o_fgot[i], m_fgot[i]);
        end
        if (pulse2) pcnt2++;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_pulse[i] = 0; m_flag[i] = 0; m_err[i] = 0; m_smp[i] = 0; m_fexp[i] = 0; m_fgot[i] = 0;
            d_out[i] = 2'd0;
        end

        // Reset for three cycles, then a clean 0..3 stream.
        repeat (3) step(1'b0, 2'd0, 1'b0, 1'b1, 0);
        check_eq("rst_smp0", o_smp[0], 0);
        check_eq("rst_flag1", o_flag[1], 0);
        for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 1'b0, 1'b0, 0);
        repeat (4) step(1'b0, 2'd0, 1'b0, 1'b0, 0);
        check_eq("p1_smp0", o_smp[0], 4);
        check_eq("p1_err0", o_err[0], 0);
        check_eq("p1_smp1", o_smp[1], 4);

        // Single injected error: 2 expected, 0 observed.
        step(1'b0, 2'd0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 1'b0, 1'b0, 2);
        repeat (4) step(1'b0, 2'd0, 1'b0, 1'b0, 2);
        check_eq("p2_err0", o_err[0], 1);
        check_eq("p2_flag0", o_flag[0], 1);
        check_eq("p2_fexp0", o_fexp[0], 2);
        check_eq("p2_fgot0", o_fgot[0], 0);

        // en gaps 1,1,0,1 then drain.
        step(1'b0, 2'd0, 1'b1, 1'b0, 0);
        step(1'b1, 2'd1, 1'b0, 1'b0, 0);
        step(1'b1, 2'd2, 1'b0, 1'b0, 0);
        step(1'b0, 2'd3, 1'b0, 1'b0, 0);
        step(1'b1, 2'd3, 1'b0, 1'b0, 0);
        repeat (5) step(1'b0, 2'd0, 1'b0, 1'b0, 0);
        check_eq("p3_smp1", o_smp[1], 3);
        check_eq("p3_err1", o_err[1], 0);

        // clr colliding with a mismatch after five earlier errors.
        step(1'b0, 2'd0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 6; k++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 3);
        check_eq("p4_pre_err0", o_err[0], 5);
        step(1'b0, 2'd0, 1'b1, 1'b0, 3);
        check_eq("p4_err0", o_err[0], 1);
        check_eq("p4_smp0", o_smp[0], 1);
        check_eq("p4_flag0", o_flag[0], 1);
        repeat (4) step(1'b0, 2'd0, 1'b0, 1'b0, 3);

        // Saturation on the 4-bit instance.
        step(1'b0, 2'd0, 1'b1, 1'b0, 3);
        pcnt2 = 0;
        for (int k = 0; k < 20; k++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 3);
        repeat (4) step(1'b0, 2'd0, 1'b0, 1'b0, 3);
        check_eq("sat_pulses2", pcnt2, 20);
        check_eq("sat_err2", o_err[2], 15);
        check_eq("sat_smp2", o_smp[2], 15);

        // Reset with two samples in flight, then clean traffic.
        step(1'b1, 2'd1, 1'b0, 1'b0, 3);
        step(1'b1, 2'd2, 1'b0, 1'b0, 3);
        step(1'b0, 2'd0, 1'b0, 1'b1, 3);
        for (int k = 0; k < 5; k++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 0);
        repeat (4) step(1'b0, 2'd0, 1'b0, 1'b0, 0);
        check_eq("mrst_err2", o_err[2], 0);
        check_eq("mrst_smp2", o_smp[2], 5);
        check_eq("mrst_flag2", o_flag[2], 0);

        // Random traffic with occasional clear, reset and corruption.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
